excep_ctrl: RTL

EXCEP_CTRL -- requirements
Module: excep_ctrl

---
 rtl/excep_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/excep_ctrl.sv
// rtl/excep_ctrl.sv - MEM-stage exception arbiter and flush sequencer; macro EXCEP_INT_SYNC2_EN selects a 2-flop int_i synchronizer
module excep_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] exc_req_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] badaddr_i,
    input  logic        in_delayslot_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    output logic [31:0] exception_type_o,
    output logic [31:0] exception_pc_o,
    output logic [31:0] exception_addr_o,
    output logic        delayslot_o,
    output logic [5:0]  int_o,
    output logic        flush_req_o,
    output logic        stall_req_o,
    output logic [15:0] exc_count_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, FLUSH = 2'd2} state_t;

    state_t      state;
    logic [3:0]  flush_cnt;
    logic [5:0]  int_sync;
    logic        int_pending;
    logic [31:0] winner;
    logic        accept;

`ifdef EXCEP_INT_SYNC2_EN
    logic [5:0] int_meta;

    // Two-flop synchronizer for the asynchronous interrupt lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            int_meta <= '0;
            int_sync <= '0;
        end else begin
            int_meta <= int_i;
            int_sync <= int_meta;
        end
    end
`else
    // Single register stage for the interrupt lines
    always_ff @(posedge clk) begin
        if (!rst) begin
            int_sync <= '0;
        end else begin
            int_sync <= int_i;
        end
    end
`endif

    assign int_o = int_sync;

    // Interrupts are only taken with IE set and EXL clear; hardware lines map to IM[7:2], software to IM[1:0]
    assign int_pending = cp0_status_i[0] & ~cp0_status_i[1]
                       & (|({int_sync, cp0_cause_i[9:8]} & cp0_status_i[15:8]));

    // Fixed-priority pick of a single event, ERET lowest
    always_comb begin
        winner = '0;
        if (int_pending)         winner[1]  = 1'b1;
        else if (exc_req_i[31])  winner[31] = 1'b1;
        else if (exc_req_i[30])  winner[30] = 1'b1;
        else if (exc_req_i[29])  winner[29] = 1'b1;
        else if (exc_req_i[28])  winner[28] = 1'b1;
        else if (exc_req_i[27])  winner[27] = 1'b1;
        else if (exc_req_i[26])  winner[26] = 1'b1;
        else if (exc_req_i[25])  winner[25] = 1'b1;
        else if (exc_req_i[0])   winner[0]  = 1'b1;
    end

    assign accept = mem_valid_i && (state == IDLE) && (winner != '0);

    // Event FSM: latch in IDLE, present one cycle in ISSUE, hold flush for FLUSH_CYCLES
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            flush_cnt        <= '0;
            exception_type_o <= '0;
            exception_pc_o   <= '0;
            exception_addr_o <= '0;
            delayslot_o      <= 1'b0;
            flush_req_o      <= 1'b0;
            stall_req_o      <= 1'b0;
            exc_count_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        exception_type_o <= winner;
                        exception_pc_o   <= pc_i;
                        exception_addr_o <= badaddr_i;
                        delayslot_o      <= in_delayslot_i;
                        stall_req_o      <= 1'b1;
                        state            <= ISSUE;
                        if (!winner[0] && exc_count_o != 16'hFFFF) begin
                            exc_count_o <= exc_count_o + 16'd1;
                        end
                    end
                end
                ISSUE: begin
                    exception_type_o <= '0;
                    flush_req_o      <= 1'b1;
                    flush_cnt        <= 4'(FLUSH_CYCLES - 1);
                    state            <= FLUSH;
                end
                FLUSH: begin
                    if (flush_cnt == 4'd0) begin
                        flush_req_o <= 1'b0;
                        stall_req_o <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
